// File: rtl/em_project_final_pd_vga_pattern_gen_if.sv
// Video port bundle for the VGA pattern generator: PIO control word in, timing + RGB out.
// master = the generator, slave = whoever drives ctrl_word and consumes the video.
interface em_project_final_pd_vga_pattern_gen_if;
    logic [9:0] ctrl_word;
    logic       vga_hs;
    logic       vga_vs;
    logic       vga_de;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;
    logic       frame_start;

    modport master (
        input  ctrl_word,
        output vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b, frame_start
    );

    modport slave (
        output ctrl_word,
        input  vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b, frame_start
    );
endinterface

// File: rtl/em_project_final_pd_vga_pattern_gen.sv
// 640x480@60 VGA timing + test-pattern generator; control word is latched only at frame end.
// Optional VGA_PATTERN_GEN_SYNC_EN: 2-flop sync + stability filter on ctrl_word.
module em_project_final_pd_vga_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic clk,
    input  logic reset,
    em_project_final_pd_vga_pattern_gen_if.master vif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Pattern maths uses x[9:2] / y[8:1], so counters are a fixed 10 bits.
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] H_RIGHT  = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_BOTTOM = 10'(V_ACTIVE - 1);
    localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [9:0]  shadow_q, shadow_d;
    logic [9:0]  ctrl_src;
    logic        frame_end;

    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        de_q, de_d;
    logic        fs_q, fs_d;
    logic [23:0] rgb_q, rgb_d;

    logic        active;
    logic        border;
    logic [2:0]  bar_idx;
    logic [5:0]  p;
    logic [23:0] pix_rgb;

`ifdef VGA_PATTERN_GEN_SYNC_EN
    logic [9:0] sync1_q, sync1_d;
    logic [9:0] sync2_q, sync2_d;
    logic [9:0] stable_q, stable_d;

    // A word that differs between consecutive samples is mid-transition; keep the old one.
    always_comb begin
        sync1_d  = vif.ctrl_word;
        sync2_d  = sync1_q;
        stable_d = (sync1_q == sync2_q) ? sync2_q : stable_q;
        ctrl_src = stable_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
        end
    end
`else
    always_comb ctrl_src = vif.ctrl_word;
`endif

    always_comb begin
        frame_end = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
        h_cnt_d   = h_cnt_q + 10'd1;
        v_cnt_d   = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
        end
        // Loading on the last pixel makes the new word live exactly from pixel (0,0).
        shadow_d = frame_end ? ctrl_src : shadow_q;
    end

    always_comb begin
        active  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        border  = (h_cnt_q == '0) || (h_cnt_q == H_RIGHT) ||
                  (v_cnt_q == '0) || (v_cnt_q == V_BOTTOM);
        bar_idx = 3'(h_cnt_q / 10'd80);
        p       = shadow_q[9:4];
        case (shadow_q[3:1])
            3'd0:    pix_rgb = {{4{p[5:4]}}, {4{p[3:2]}}, {4{p[1:0]}}};
            3'd1:    pix_rgb = {{8{bar_idx[2]}}, {8{bar_idx[1]}}, {8{bar_idx[0]}}};
            3'd2:    pix_rgb = {3{h_cnt_q[9:2]}};
            3'd3:    pix_rgb = {3{v_cnt_q[8:1]}};
            3'd4:    pix_rgb = {24{h_cnt_q[5] ^ v_cnt_q[5]}};
            3'd5:    pix_rgb = {24{border}};
            default: pix_rgb = '0;
        endcase

        rgb_d = (active && shadow_q[0]) ? pix_rgb : '0;
        de_d  = active;
        hs_d  = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
        vs_d  = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
        fs_d  = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            shadow_q <= '0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            de_q     <= 1'b0;
            fs_q     <= 1'b0;
            rgb_q    <= '0;
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            shadow_q <= shadow_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            de_q     <= de_d;
            fs_q     <= fs_d;
            rgb_q    <= rgb_d;
        end
    end

    assign vif.vga_hs      = hs_q;
    assign vif.vga_vs      = vs_q;
    assign vif.vga_de      = de_q;
    assign vif.frame_start = fs_q;
    assign vif.vga_r       = rgb_q[23:16];
    assign vif.vga_g       = rgb_q[15:8];
    assign vif.vga_b       = rgb_q[7:0];

endmodule

// File: tb/tb_em_project_final_pd_vga_pattern_gen.sv
// Directed bench for the VGA pattern generator, run with a shrunken frame so many frames fit.
// Pixel positions come from a cycle count since reset release, independent of the DUT.
module tb_em_project_final_pd_vga_pattern_gen;

    localparam int HA = 168, HF = 2, HS = 4, HB = 2;
    localparam int VA = 34,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    em_project_final_pd_vga_pattern_gen_if vif ();

    em_project_final_pd_vga_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .vif  (vif)
    );

    typedef struct {
        logic [9:0]  nxt;
        int          x;
        int          y;
        logic [24:0] exp;
    } vec_t;

    vec_t tv[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always @(posedge clk or posedge reset)
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;

    // Output pixel visible after the c-th edge since release is pixel c-1 (one cycle latency).
    function automatic int px(input int c);
        return ((c - 1) % FT) % HT;
    endfunction
    function automatic int py(input int c);
        return ((c - 1) % FT) / HT;
    endfunction
    function automatic logic [3:0] exp_tim(input int c);
        int x, y;
        x = px(c);
        y = py(c);
        return {!(x >= HA + HF && x < HA + HF + HS),
                !(y >= VA + VF && y < VA + VF + VS),
                (x < HA) && (y < VA),
                (x == 0) && (y == 0)};
    endfunction

    wire [23:0] rgb = {vif.vga_r, vif.vga_g, vif.vga_b};

    int   mon_err = 0, f0_err = 0;
    logic prev_hs = 1'b1, prev_vs = 1'b1;
    int   hs_f1 = -1, hs_f2 = -1, hs_low = -1;
    int   vs_f1 = -1, vs_f2 = -1, vs_low = -1;
    int   fs_1 = -1, fs_2 = -1;

    always @(negedge clk) begin
        if (!reset && cyc >= 1) begin
            if ({vif.vga_hs, vif.vga_vs, vif.vga_de, vif.frame_start} != exp_tim(cyc) ||
                (!vif.vga_de && rgb != 24'h0))
                mon_err <= mon_err + 1;
            if (cyc - 1 < FT && rgb != 24'h0)
                f0_err <= f0_err + 1;
            prev_hs <= vif.vga_hs;
            prev_vs <= vif.vga_vs;
            if (prev_hs && !vif.vga_hs) begin
                if (hs_f1 < 0) hs_f1 <= cyc;
                else if (hs_f2 < 0) hs_f2 <= cyc;
            end
            if (!prev_hs && vif.vga_hs && hs_f1 >= 0 && hs_low < 0) hs_low <= cyc - hs_f1;
            if (prev_vs && !vif.vga_vs) begin
                if (vs_f1 < 0) vs_f1 <= cyc;
                else if (vs_f2 < 0) vs_f2 <= cyc;
            end
            if (!prev_vs && vif.vga_vs && vs_f1 >= 0 && vs_low < 0) vs_low <= cyc - vs_f1;
            if (vif.frame_start) begin
                if (fs_1 < 0) fs_1 <= cyc;
                else if (fs_2 < 0) fs_2 <= cyc;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic wait_pix(input int x, input int y);
        int  n;
        bit  found;
        n     = 0;
        found = 1'b0;
        while (!found && n <= FT + 8) begin
            @(negedge clk);
            n++;
            found = (cyc >= 1) && (px(cyc) == x) && (py(cyc) == y);
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL wait_pix(%0d,%0d): timed out after %0d cycles", x, y, n);
        end
    endtask

    task automatic add(input logic [9:0] n, input int x, input int y,
                       input logic de, input logic [23:0] c);
        vec_t v;
        v.nxt = n; v.x = x; v.y = y; v.exp = {de, c};
        tv.push_back(v);
    endtask

    initial begin
        // Frame 0: shadow cleared by reset -> black.
        add(10'h000,   0,  0, 1'b1, 24'h000000);
        add(10'h003, 100, 10, 1'b1, 24'h000000);
        // Frame 1: colour bars.
        add(10'h003,   0,  0, 1'b1, 24'h000000);
        add(10'h003,  80,  0, 1'b1, 24'h0000FF);
        add(10'h003, 160,  3, 1'b1, 24'h00FF00);
        add(10'h003, 167,  5, 1'b1, 24'h00FF00);
        add(10'h3F1, 170,  5, 1'b0, 24'h000000);
        // Frame 2: solid p=3F; switching to h-grad mid-frame must not tear.
        add(10'h3F5,   0,  0, 1'b1, 24'hFFFFFF);
        add(10'h3F5,  50, 20, 1'b1, 24'hFFFFFF);
        // Frame 3: h-grad.
        add(10'h3F5,   4,  0, 1'b1, 24'h010101);
        add(10'h009, 167, 33, 1'b1, 24'h292929);
        // Frame 4: checker.
        add(10'h009,   0,  0, 1'b1, 24'h000000);
        add(10'h009,  32,  0, 1'b1, 24'hFFFFFF);
        add(10'h009,  32, 32, 1'b1, 24'h000000);
        add(10'h009,  64, 33, 1'b1, 24'hFFFFFF);
        add(10'h00B, 170, 33, 1'b0, 24'h000000);
        // Frame 5: border.
        add(10'h00B,   0,  0, 1'b1, 24'hFFFFFF);
        add(10'h00B,   5,  0, 1'b1, 24'hFFFFFF);
        add(10'h00B,   5,  1, 1'b1, 24'h000000);
        add(10'h00B,   0,  7, 1'b1, 24'hFFFFFF);
        add(10'h00B, 166,  7, 1'b1, 24'h000000);
        add(10'h00B, 167,  7, 1'b1, 24'hFFFFFF);
        add(10'h007,   5, 33, 1'b1, 24'hFFFFFF);
        // Frame 6: v-grad.
        add(10'h007,  10,  0, 1'b1, 24'h000000);
        add(10'h007,  10,  3, 1'b1, 24'h010101);
        add(10'h3F0,  10, 33, 1'b1, 24'h101010);
        // Frame 7: enable=0 with a bright solid selected.
        add(10'h3F0,   0,  0, 1'b1, 24'h000000);
        add(10'h3FD,  50, 10, 1'b1, 24'h000000);
        // Frame 8: reserved pattern 6.
        add(10'h3FD,   0,  0, 1'b1, 24'h000000);
        add(10'h3FD,  50, 10, 1'b1, 24'h000000);

        vif.ctrl_word = 10'h000;
        repeat (3) @(negedge clk);
        chk("reset_state", {28'h0, vif.vga_hs, vif.vga_vs, vif.vga_de, vif.frame_start}, 32'hC);
        chk("reset_rgb", {8'h0, rgb}, 32'h0);
        #2 reset = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            wait_pix(tv[i].x, tv[i].y);
            chk($sformatf("vec%0d(%0d,%0d)", i, tv[i].x, tv[i].y),
                {7'h0, vif.vga_de, rgb}, {7'h0, tv[i].exp});
            vif.ctrl_word = tv[i].nxt;
        end

        chk("fs_first_cycle", fs_1, 1);
        chk("fs_period", fs_2 - fs_1, FT);
        chk("hs_period", hs_f2 - hs_f1, HT);
        chk("hs_low_width", hs_low, HS);
        chk("vs_period", vs_f2 - vs_f1, FT);
        chk("vs_low_width", vs_low, VS * HT);

        // Frame-end boundary: last-pixel sample is loaded, anything after waits a frame.
`ifdef VGA_PATTERN_GEN_SYNC_EN
        wait_pix(HT - 20, VT - 1);
        vif.ctrl_word = 10'h271;
        wait_pix(HT - 8, VT - 1);
        for (int i = 0; i < 7; i++) begin
            vif.ctrl_word = i[0] ? 10'h3F0 : 10'h00B;
            @(negedge clk);
        end
        vif.ctrl_word = 10'h3F0;
`else
        wait_pix(HT - 2, VT - 1);
        vif.ctrl_word = 10'h271;
        wait_pix(HT - 1, VT - 1);
        vif.ctrl_word = 10'h3F0;
`endif
        wait_pix(0, 0);
        chk("boundary_load", {7'h0, vif.vga_de, rgb}, {7'h0, 1'b1, 24'hAA55FF});
        vif.ctrl_word = 10'h271;
        wait_pix(100, 20);
        chk("pre_reset_pix", {7'h0, vif.vga_de, rgb}, {7'h0, 1'b1, 24'hAA55FF});

        // Mid-frame reset: idle at once, restart at (0,0) with a black first frame.
        #2 reset = 1'b1;
        #1 chk("reset_async_idle",
               {4'h0, vif.vga_hs, vif.vga_vs, vif.vga_de, vif.frame_start, rgb},
               {4'h0, 4'hC, 24'h0});
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_hold_idle",
            {4'h0, vif.vga_hs, vif.vga_vs, vif.vga_de, vif.frame_start, rgb},
            {4'h0, 4'hC, 24'h0});
        #2 reset = 1'b0;
        @(negedge clk);
        chk("restart_fs", {6'h0, vif.frame_start, vif.vga_de, rgb}, {6'h0, 2'b11, 24'h0});
        wait_pix(50, 10);
        chk("restart_black", {7'h0, vif.vga_de, rgb}, {7'h0, 1'b1, 24'h0});
        @(negedge clk);

        chk("timing_stream_errors", mon_err, 0);
        chk("first_frame_rgb_errors", f0_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
